// File: rtl/com_bus_arbiter_pkg.sv
// Shared constants and FSM encodings for the common-bus arbiter.
// Every block that needs the core count or the hold limit imports them from here.
package com_bus_arbiter_pkg;

    localparam int NUM_CORES = 4;
    localparam int HOLD_MAX  = 255;
    localparam int CNT_W     = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_TURN  = 2'd2
    } proc_state_e;

endpackage

// File: rtl/com_bus_arbiter_rr_pick.sv
// Round-robin pick: the first requester at or after ptr, scanning upward with wrap.
// Purely combinational, so any multi-requester resource can reuse it.
module com_bus_arbiter_rr_pick #(
    parameter int NUM_CORES = 4,
    parameter int PTR_W     = 2
) (
    input  logic [NUM_CORES-1:0] req,
    input  logic [PTR_W-1:0]     ptr,
    output logic [NUM_CORES-1:0] gnt,
    output logic [PTR_W-1:0]     idx
);

    logic [PTR_W-1:0] pos_s;

    // Scan from the farthest offset down so the nearest requester is written last
    always_comb begin
        idx   = {PTR_W{1'b0}};
        pos_s = {PTR_W{1'b0}};
        for (int i = NUM_CORES - 1; i >= 0; i--) begin
            pos_s = PTR_W'((int'(ptr) + i) % NUM_CORES);
            idx   = req[pos_s] ? pos_s : idx;
        end
        gnt = (|req) ? (NUM_CORES'(1) << idx) : {NUM_CORES{1'b0}};
    end

endmodule

// File: rtl/com_bus_arbiter.sv
// Common-bus arbiter for the 4-core MESI system: round-robin processor grants with
// a turnaround cycle, fixed-priority snoop grants, and invalidation-done combining.
module com_bus_arbiter #(
    parameter int NUM_CORES = com_bus_arbiter_pkg::NUM_CORES,
    parameter int HOLD_MAX  = com_bus_arbiter_pkg::HOLD_MAX,
    parameter int CNT_W     = com_bus_arbiter_pkg::CNT_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_CORES-1:0] Com_Bus_Req_proc,
    input  logic [NUM_CORES-1:0] Com_Bus_Req_snoop,
    input  logic                 Invalidate,
    input  logic [NUM_CORES-1:0] Invalidation_done,
    output logic [NUM_CORES-1:0] Com_Bus_Gnt_proc,
    output logic [NUM_CORES-1:0] Com_Bus_Gnt_snoop,
    output logic                 All_Invalidation_done,
    output logic                 Bus_timeout
);

    import com_bus_arbiter_pkg::*;

    localparam int PTR_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

    proc_state_e          state_r, state_nxt_s;
    logic [NUM_CORES-1:0] gnt_proc_r, gnt_proc_nxt_s;
    logic [NUM_CORES-1:0] gnt_snoop_r, gnt_snoop_nxt_s;
    logic [PTR_W-1:0]     owner_r, owner_nxt_s;
    logic [PTR_W-1:0]     rr_ptr_r, rr_ptr_nxt_s;
    logic [CNT_W-1:0]     hold_cnt_r, hold_cnt_nxt_s;
    logic                 timeout_r, timeout_nxt_s;
    logic                 all_inv_r, all_inv_nxt_s;
    logic [NUM_CORES-1:0] pick_gnt_s;
    logic [PTR_W-1:0]     pick_idx_s;
    logic [NUM_CORES-1:0] snoop_low_s;

    com_bus_arbiter_rr_pick #(
        .NUM_CORES (NUM_CORES),
        .PTR_W     (PTR_W)
    ) u_rr_pick (
        .req (Com_Bus_Req_proc),
        .ptr (rr_ptr_r),
        .gnt (pick_gnt_s),
        .idx (pick_idx_s)
    );

    // Processor ownership FSM: next state, grant, pointer and hold counter
    always_comb begin
        state_nxt_s    = state_r;
        gnt_proc_nxt_s = gnt_proc_r;
        owner_nxt_s    = owner_r;
        rr_ptr_nxt_s   = rr_ptr_r;
        hold_cnt_nxt_s = hold_cnt_r;
        timeout_nxt_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (|Com_Bus_Req_proc) begin
                    state_nxt_s    = ST_GRANT;
                    gnt_proc_nxt_s = pick_gnt_s;
                    owner_nxt_s    = pick_idx_s;
                    hold_cnt_nxt_s = {CNT_W{1'b0}};
                    if (pick_idx_s == PTR_W'(NUM_CORES - 1)) begin
                        rr_ptr_nxt_s = {PTR_W{1'b0}};
                    end else begin
                        rr_ptr_nxt_s = pick_idx_s + PTR_W'(1);
                    end
                end else begin
                    gnt_proc_nxt_s = {NUM_CORES{1'b0}};
                end
            end
            ST_GRANT: begin
                // A voluntary release wins over a coincident timeout: no pulse then
                if (!Com_Bus_Req_proc[owner_r]) begin
                    state_nxt_s    = ST_TURN;
                    gnt_proc_nxt_s = {NUM_CORES{1'b0}};
                end else if (hold_cnt_r == CNT_W'(HOLD_MAX)) begin
                    state_nxt_s    = ST_TURN;
                    gnt_proc_nxt_s = {NUM_CORES{1'b0}};
                    timeout_nxt_s  = 1'b1;
                end else begin
                    hold_cnt_nxt_s = hold_cnt_r + CNT_W'(1);
                end
            end
            ST_TURN: begin
                state_nxt_s    = ST_IDLE;
                gnt_proc_nxt_s = {NUM_CORES{1'b0}};
            end
            default: begin
                state_nxt_s    = ST_IDLE;
                gnt_proc_nxt_s = {NUM_CORES{1'b0}};
            end
        endcase
    end

    // Snoop grant: lowest-index requester, held until its request drops
    always_comb begin
        snoop_low_s = Com_Bus_Req_snoop & (~Com_Bus_Req_snoop + NUM_CORES'(1));
        if (gnt_snoop_r == {NUM_CORES{1'b0}}) begin
            gnt_snoop_nxt_s = snoop_low_s;
        end else if ((Com_Bus_Req_snoop & gnt_snoop_r) == {NUM_CORES{1'b0}}) begin
            gnt_snoop_nxt_s = {NUM_CORES{1'b0}};
        end else begin
            gnt_snoop_nxt_s = gnt_snoop_r;
        end
    end

    // Invalidation complete: the owner's own acknowledge is masked by its grant bit
    always_comb begin
        all_inv_nxt_s = (state_r == ST_GRANT) && Invalidate &&
                        (&(Invalidation_done | gnt_proc_r));
    end

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            gnt_proc_r  <= {NUM_CORES{1'b0}};
            gnt_snoop_r <= {NUM_CORES{1'b0}};
            owner_r     <= {PTR_W{1'b0}};
            rr_ptr_r    <= {PTR_W{1'b0}};
            hold_cnt_r  <= {CNT_W{1'b0}};
            timeout_r   <= 1'b0;
            all_inv_r   <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            gnt_proc_r  <= gnt_proc_nxt_s;
            gnt_snoop_r <= gnt_snoop_nxt_s;
            owner_r     <= owner_nxt_s;
            rr_ptr_r    <= rr_ptr_nxt_s;
            hold_cnt_r  <= hold_cnt_nxt_s;
            timeout_r   <= timeout_nxt_s;
            all_inv_r   <= all_inv_nxt_s;
        end
    end

    assign Com_Bus_Gnt_proc      = gnt_proc_r;
    assign Com_Bus_Gnt_snoop     = gnt_snoop_r;
    assign All_Invalidation_done = all_inv_r;
    assign Bus_timeout           = timeout_r;

endmodule

// File: tb/tb_com_bus_arbiter.sv
// Directed table-driven bench for com_bus_arbiter (HOLD_MAX = 4 to keep timeouts short),
// plus a hand-written asynchronous reset-mid-grant sequence.
module tb_com_bus_arbiter;

    logic       clk;
    logic       rst;
    logic [3:0] req_proc;
    logic [3:0] req_snoop;
    logic       inv;
    logic [3:0] inv_done;
    logic [3:0] gnt_proc;
    logic [3:0] gnt_snoop;
    logic       all_inv;
    logic       timeout;

    int n_checks;
    int n_fail;

    typedef struct {
        logic       rst;
        logic [3:0] rp;
        logic [3:0] rs;
        logic       inv;
        logic [3:0] done;
        logic [3:0] egp;
        logic [3:0] egs;
        logic       eai;
        logic       eto;
    } vec_t;

    vec_t tbl[$];

    com_bus_arbiter #(
        .NUM_CORES (4),
        .HOLD_MAX  (4),
        .CNT_W     (8)
    ) dut (
        .clk                   (clk),
        .rst                   (rst),
        .Com_Bus_Req_proc      (req_proc),
        .Com_Bus_Req_snoop     (req_snoop),
        .Invalidate            (inv),
        .Invalidation_done     (inv_done),
        .Com_Bus_Gnt_proc      (gnt_proc),
        .Com_Bus_Gnt_snoop     (gnt_snoop),
        .All_Invalidation_done (all_inv),
        .Bus_timeout           (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic r, input logic [3:0] rp, input logic [3:0] rs,
                                input logic iv, input logic [3:0] dn,
                                input logic [3:0] gp, input logic [3:0] gs,
                                input logic ai, input logic to);
        vec_t v;
        v.rst = r;  v.rp = rp;  v.rs = rs;  v.inv = iv; v.done = dn;
        v.egp = gp; v.egs = gs; v.eai = ai; v.eto = to;
        return v;
    endfunction

    task automatic check(input string name, input int step, input logic [3:0] act,
                         input logic [3:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s step %0d: got %b, expected %b", name, step, act, exp);
        end
    endtask

    task automatic check_all(input int step, input logic [3:0] gp, input logic [3:0] gs,
                             input logic ai, input logic to);
        check("gnt_proc", step, gnt_proc, gp);
        check("gnt_snoop", step, gnt_snoop, gs);
        check("all_inv_done", step, {3'b000, all_inv}, {3'b000, ai});
        check("bus_timeout", step, {3'b000, timeout}, {3'b000, to});
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        rst       = 1'b0;
        req_proc  = 4'b0000;
        req_snoop = 4'b0000;
        inv       = 1'b0;
        inv_done  = 4'b0000;

        // Reset state
        tbl.push_back(mk(1'b1, 4'b0000, 4'b0000, 1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0));
        // Single requester core 2, invalidation checks while it owns the bus
        tbl.push_back(mk(1'b0, 4'b0100, 4'b0000, 1'b0, 4'b0000, 4'b0100, 4'b0000, 1'b0, 1'b0));
        tbl.push_back(mk(1'b0, 4'b0100, 4'b0000, 1'b1, 4'b1011, 4'b0100, 4'b0000, 1'b1, 1'b0));
        tbl.push_back(mk(1'b0, 4'b0100, 4'b0000, 1'b1, 4'b0111, 4'b0100, 4'b0000, 1'b0, 1'b0));
        tbl.push_back(mk(1'b0, 4'b0000, 4'b0000, 1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0));
        tbl.push_back(mk(1'b0, 4'b0000, 4'b0000, 1'b1, 4'b1111, 4'b0000, 4'b0000, 1'b0, 1'b0));
        tbl.push_back(mk(1'b0, 4'b0000, 4'b0000, 1'b1, 4'b1111, 4'b0000, 4'b0000, 1'b0, 1'b0));
        // Round-robin fairness from a fresh pointer: cores 0,1,2,3,0
        tbl.push_back(mk(1'b1, 4'b0000, 4'b0000, 1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0));
        for (int c = 0; c < 4; c++) begin
            logic [3:0] own;
            own = 4'b0001 << c;
            for (int k = 0; k < 3; k++)
                tbl.push_back(mk(1'b0, 4'b1111, 4'b0000, 1'b0, 4'b0000, own, 4'b0000, 1'b0, 1'b0));
            tbl.push_back(mk(1'b0, 4'b1111 & ~own, 4'b0000, 1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0));
            tbl.push_back(mk(1'b0, 4'b1111, 4'b0000, 1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0));
        end
        tbl.push_back(mk(1'b0, 4'b1111, 4'b0000, 1'b0, 4'b0000, 4'b0001, 4'b0000, 1'b0, 1'b0));
        tbl.push_back(mk(1'b0, 4'b0000, 4'b0000, 1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0));
        tbl.push_back(mk(1'b0, 4'b0000, 4'b0000, 1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0));
        // Snoop concurrency with proc owner core 0 (pointer is at 1)
        tbl.push_back(mk(1'b0, 4'b0001, 4'b1010, 1'b0, 4'b0000, 4'b0001, 4'b0010, 1'b0, 1'b0));
        tbl.push_back(mk(1'b0, 4'b0001, 4'b1010, 1'b0, 4'b0000, 4'b0001, 4'b0010, 1'b0, 1'b0));
        tbl.push_back(mk(1'b0, 4'b0001, 4'b1000, 1'b0, 4'b0000, 4'b0001, 4'b0000, 1'b0, 1'b0));
        tbl.push_back(mk(1'b0, 4'b0001, 4'b1000, 1'b0, 4'b0000, 4'b0001, 4'b1000, 1'b0, 1'b0));
        tbl.push_back(mk(1'b0, 4'b0000, 4'b1000, 1'b0, 4'b0000, 4'b0000, 4'b1000, 1'b0, 1'b0));
        tbl.push_back(mk(1'b0, 4'b0000, 4'b0000, 1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0));
        tbl.push_back(mk(1'b0, 4'b0000, 4'b0000, 1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0));
        // Same core on both sides: both grants at the same edge
        tbl.push_back(mk(1'b0, 4'b0010, 4'b0010, 1'b0, 4'b0000, 4'b0010, 4'b0010, 1'b0, 1'b0));
        tbl.push_back(mk(1'b0, 4'b0000, 4'b0000, 1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0));
        tbl.push_back(mk(1'b0, 4'b0000, 4'b0000, 1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0));
        // Timeout: core 1 holds for HOLD_MAX+1 = 5 cycles, then core 2 wins
        tbl.push_back(mk(1'b0, 4'b0010, 4'b0000, 1'b0, 4'b0000, 4'b0010, 4'b0000, 1'b0, 1'b0));
        for (int k = 0; k < 4; k++)
            tbl.push_back(mk(1'b0, 4'b0110, 4'b0000, 1'b0, 4'b0000, 4'b0010, 4'b0000, 1'b0, 1'b0));
        tbl.push_back(mk(1'b0, 4'b0110, 4'b0000, 1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b1));
        tbl.push_back(mk(1'b0, 4'b0110, 4'b0000, 1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0));
        tbl.push_back(mk(1'b0, 4'b0110, 4'b0000, 1'b0, 4'b0000, 4'b0100, 4'b0000, 1'b0, 1'b0));
        tbl.push_back(mk(1'b0, 4'b0000, 4'b0000, 1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0));
        tbl.push_back(mk(1'b0, 4'b0000, 4'b0000, 1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0));

        #1;
        for (int i = 0; i < tbl.size(); i++) begin
            rst       = tbl[i].rst;
            req_proc  = tbl[i].rp;
            req_snoop = tbl[i].rs;
            inv       = tbl[i].inv;
            inv_done  = tbl[i].done;
            @(negedge clk);
            check_all(i, tbl[i].egp, tbl[i].egs, tbl[i].eai, tbl[i].eto);
        end

        // Reset between edges while core 0 holds both grants (pointer is at 3)
        req_proc  = 4'b0001;
        req_snoop = 4'b0001;
        @(negedge clk);
        check_all(1000, 4'b0001, 4'b0001, 1'b0, 1'b0);
        #2 rst = 1'b1;
        #1 check_all(1001, 4'b0000, 4'b0000, 1'b0, 1'b0);
        @(negedge clk);
        rst       = 1'b0;
        req_proc  = 4'b1000;
        req_snoop = 4'b0000;
        @(negedge clk);
        check_all(1002, 4'b1000, 4'b0000, 1'b0, 1'b0);
        req_proc = 4'b0000;
        @(negedge clk);
        check_all(1003, 4'b0000, 4'b0000, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/com_bus_arbiter.md
# com_bus_arbiter

Arbiter for the shared common bus of the 4-core MESI system. It collects the per-cache processor-side and snoop-side bus requests and issues one-hot grants. Processor-side ownership uses round-robin with a bus-turnaround cycle, and snoop-side responses use fixed priority. It also combines the per-cache `Invalidation_done` flags into `All_Invalidation_done`. It sits at top level between the four cache wrappers and the common address/data bus.

## Interface
- `NUM_CORES`, 4: number of cache wrappers; one bit per core on every vector port.
- `HOLD_MAX`, 255: maximum number of consecutive cycles a processor grant may be held.
- `CNT_W`, 8: width of the hold counter; must satisfy 2^CNT_W > HOLD_MAX.

- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `Com_Bus_Req_proc` in NUM_CORES: processor-side bus request, one bit per cache.
- `Com_Bus_Req_snoop` in NUM_CORES: snoop-side bus request, one bit per cache (used to flush or supply data).
- `Invalidate` in 1: the owner is broadcasting an invalidation.
- `Invalidation_done` in NUM_CORES: per-cache invalidation acknowledge.
- `Com_Bus_Gnt_proc` out NUM_CORES: one-hot-or-zero processor grant.
- `Com_Bus_Gnt_snoop` out NUM_CORES: one-hot-or-zero snoop grant.
- `All_Invalidation_done` out 1: every non-owner cache has acknowledged the invalidation.
- `Bus_timeout` out 1: one-cycle pulse when a processor grant is forcibly revoked.

## Operation
- Processor FSM has three states:
  - IDLE: no processor grant.
  - GRANT: one processor grant active.
  - TURN: one-cycle bus turnaround.
- IDLE → GRANT when any `Com_Bus_Req_proc` bit is high.
  - Winner is the first requester at or after `rr_ptr`, scanning upward with wrap from NUM_CORES-1 to 0.
  - `Com_Bus_Gnt_proc[winner]` is registered high.
  - `rr_ptr` is set to winner+1 mod NUM_CORES.
  - `hold_cnt` is cleared to 0.
- GRANT → TURN when the owner's request bit is sampled low. The grant drops at that edge.
- GRANT → TURN when `hold_cnt` reaches HOLD_MAX.
  - The grant drops and `Bus_timeout` pulses high for one cycle.
  - `rr_ptr` still advances past the owner.
- While in GRANT, `hold_cnt` increments every cycle and saturates at HOLD_MAX. It never wraps.
- TURN → IDLE unconditionally. No grant is issued during TURN.
- Requests from non-owners are ignored during GRANT. Requests are not latched; a requester must hold its request until granted.
- Snoop arbitration is independent of processor ownership. A snoop grant may coexist with a processor grant, including one given to the same core.
  - With no snoop grant active, the lowest-index asserted `Com_Bus_Req_snoop` bit is granted at the next edge.
  - The snoop grant is held until that request bit is sampled low, then drops at that edge.
  - A new snoop grant may issue at the edge after the drop, never at the same edge.
- `All_Invalidation_done` is registered high when all of the following hold:
  - the processor FSM is in GRANT;
  - `Invalidate` is high;
  - `Invalidation_done` is high for every core other than the owner. The owner's bit is don't-care.
- `All_Invalidation_done` is registered low otherwise, including in IDLE and TURN.

## Timing
- Reset values:
  - `Com_Bus_Gnt_proc` = 0.
  - `Com_Bus_Gnt_snoop` = 0.
  - `All_Invalidation_done` = 0.
  - `Bus_timeout` = 0.
  - FSM = IDLE, `rr_ptr` = 0, `hold_cnt` = 0.
- Reset asserted mid-transaction clears all grants immediately (asynchronously). No TURN cycle follows.
- Request to grant latency is 1 cycle (request sampled at edge N, grant visible after edge N).
- Request drop to grant drop is 1 cycle.
- Minimum gap between successive processor grants is one TURN cycle plus one IDLE cycle. A new grant appears 2 edges after the previous grant drops.
- Timeout revoke happens at the edge where `hold_cnt` equals HOLD_MAX. Total grant duration is HOLD_MAX+1 cycles.
- Simultaneous processor and snoop requests from the same core are arbitrated independently; both grants issue at the same edge.
- `All_Invalidation_done` lags its inputs by 1 cycle.
- All outputs are registered; there are no combinational input-to-output paths.

## Structure
- `NUM_CORES`, `HOLD_MAX`, `CNT_W` and the FSM state encodings belong in the shared `cache_def` include.
- The round-robin pick (request vector plus pointer in, one-hot out) is a natural sub-module `rr_pick`. It is purely combinational and reused for any future multi-requester resource.
- Snoop fixed-priority selection and invalidation AND-reduction stay inline.

## Test plan
- Single requester: after reset, `Com_Bus_Req_proc` = 4'b0100 → `Com_Bus_Gnt_proc` = 4'b0100 after 1 edge. Dropping the request → grant 0 after 1 edge, then a 2-edge gap.
- Round-robin fairness: `Com_Bus_Req_proc` = 4'b1111 held, each owner releasing after 3 cycles → grant order cores 0,1,2,3,0, each separated by TURN+IDLE.
- Timeout with HOLD_MAX = 4: core 1 holds its request indefinitely → grant lasts 5 cycles, `Bus_timeout` pulses 1 cycle, and core 2 (also requesting) is granted next.
- Snoop concurrency: proc grant to core 0 while snoop requests 4'b1010 → snoop grant 4'b0010. Core 1 drops its snoop request → grant 0 for 1 cycle, then 4'b1000. The proc grant is unaffected throughout.
- Invalidation: owner core 2, `Invalidate` = 1, `Invalidation_done` = 4'b1011 → `All_Invalidation_done` = 1 after 1 edge. With 4'b0111 → it stays 0.
- Reset mid-grant: assert `rst` between clock edges while the proc grant is 4'b0001 → all outputs 0 immediately. After release, a request from core 3 is granted in 1 cycle.
